// File: rtl/sum_accumulator.sv
// sum_accumulator: collects COUNT adder results per batch and
// presents total, average and sticky overflow on a held handshake.
module sum_accumulator #(
  parameter int WIDTH      = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int COUNT      = 4,
  parameter int LOG2_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0]     out_avg,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int CNT_W = LOG2_COUNT + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [1:0]           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;

  logic                 xfer;
  logic                 take;
  logic [ACC_WIDTH:0]   add_full;
  logic [ACC_WIDTH-1:0] shifted;

  // Handshake qualifiers and the widened add that exposes the carry.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    xfer      = in_ready && in_valid;
    take      = out_valid && out_ready;
    add_full  = {1'b0, acc} + (ACC_WIDTH + 1)'(in_data);
    shifted   = acc >> LOG2_COUNT;
  end

  // Results are visible only while the batch is being offered.
  always_comb begin
    out_sum = '0;
    out_avg = '0;
    out_ovf = 1'b0;
    if (state == DONE) begin
      out_sum = acc;
      out_avg = WIDTH'(shifted);
      out_ovf = ovf;
    end
  end

  // Batch FSM plus accumulator, sample counter and sticky carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc <= add_full[ACC_WIDTH-1:0];
            cnt <= cnt + 1'b1;
            ovf <= ovf | add_full[ACC_WIDTH];
            if (cnt == LAST) state <= DONE;
          end
        end
        DONE: begin
          if (take) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed and randomized batches checked
// against an arithmetic model of batch total, average and overflow.
module tb_sum_accumulator;

  localparam int W   = 32;
  localparam int AW  = 32;
  localparam int CNT = 4;
  localparam int L2  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [W-1:0]  out_avg;
  logic          out_ovf;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] dq[$];
  bit          vq[$];

  always #5 clk = ~clk;

  sum_accumulator #(
    .WIDTH(W), .ACC_WIDTH(AW), .COUNT(CNT), .LOG2_COUNT(L2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_avg(out_avg), .out_ovf(out_ovf),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ovalid"}, out_valid, 0);
    chk({tag, "_iready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sum"}, out_sum, 0);
    chk({tag, "_avg"}, out_avg, 0);
    chk({tag, "_ovf"}, out_ovf, 0);
  endtask

  // Run one batch from the queues dq/vq; the model is the plain
  // arithmetic sum of the samples offered while valid.
  task automatic run_batch(input int hold, input bit start_mid);
    longint unsigned total;
    int got;
    int i;
    logic [31:0] s_exp;
    logic [31:0] a_exp;
    logic o_exp;
    total = 0;
    got = 0;
    i = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 32'd999;
    @(negedge clk);
    start = 1'b0;
    chk("accum_busy", busy, 1);
    while (got < CNT) begin
      if (i >= dq.size()) begin
        chk("feed_exhausted", 64'(got), 64'(CNT));
        break;
      end
      chk("accum_iready", in_ready, 1);
      chk("accum_ovalid", out_valid, 0);
      in_valid = vq[i];
      in_data = vq[i] ? dq[i] : $urandom;
      start = start_mid && (i == 1);
      if (vq[i]) begin
        total += longint'(dq[i]);
        got++;
      end
      i++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    s_exp = total[31:0];
    a_exp = s_exp / CNT;
    o_exp = (total >> 32) != 0;
    chk("done_ovalid", out_valid, 1);
    chk("done_iready", in_ready, 0);
    chk("done_busy", busy, 1);
    chk("done_sum", out_sum, s_exp);
    chk("done_avg", out_avg, a_exp);
    chk("done_ovf", out_ovf, o_exp);
    out_ready = 1'b0;
    repeat (hold) begin
      in_valid = 1'($urandom % 2);
      in_data = $urandom;
      @(negedge clk);
      chk("hold_ovalid", out_valid, 1);
      chk("hold_iready", in_ready, 0);
      chk("hold_sum", out_sum, s_exp);
      chk("hold_avg", out_avg, a_exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk_zero("after_take");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // 100,69,58,7 with valid held, 5-cycle stall in DONE
    dq = '{100, 69, 58, 7};
    vq = '{1, 1, 1, 1};
    run_batch(5, 1'b0);

    // alternating valid, data 1..8
    dq = '{1, 2, 3, 4, 5, 6, 7, 8};
    vq = '{1, 0, 1, 0, 1, 0, 1, 0};
    run_batch(1, 1'b0);

    // carry out of the accumulator, then a clean batch
    dq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vq = '{1, 1, 1, 1};
    run_batch(2, 1'b0);
    dq = '{1, 1, 1, 1};
    run_batch(0, 1'b0);

    // async reset after two samples
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'd5;
    @(negedge clk);
    in_data = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    // restart, with start asserted during ACCUM
    dq = '{10, 20, 30, 40};
    vq = '{1, 1, 1, 1};
    run_batch(1, 1'b1);

    // async reset while a result is offered
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    repeat (CNT) begin
      in_data = 32'd9;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_rst_done", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_done");
    @(negedge clk);
    rst_n = 1'b1;

    // randomized batches
    repeat (6) begin
      dq.delete();
      vq.delete();
      for (int k = 0; k < 16; k++) begin
        dq.push_back(($urandom % 4 == 0) ? 32'hFFFF_0000 | $urandom : $urandom);
        vq.push_back((k >= 10) || ($urandom % 10 < 7));
      end
      run_batch(int'($urandom % 4), 1'($urandom % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
